// File: rtl/gpio_pkg.sv
// Shared constants, register-map decode and pin indexing for the GPIO input capture block.
package gpio_pkg;

    localparam logic [31:0] GPIO_IN_BASE   = 32'h0000_1400;
    localparam logic [31:0] GPIO_RISE_BASE = 32'h0000_1420;
    localparam logic [31:0] GPIO_FALL_BASE = 32'h0000_1440;
    localparam logic [31:0] GPIO_FILT_ADR  = 32'h0000_1460;

    localparam int PinsPrWord  = 24;
    localparam int NumInWords  = 6;
    localparam int PinsPerPort = 34;

    // Which register group a bus access targets.
    typedef enum logic [1:0] {
        REG_IN   = 2'd0,
        REG_RISE = 2'd1,
        REG_FALL = 2'd2,
        REG_FILT = 2'd3
    } reg_sel_e;

    // Decoded bus access: hit flags a mapped register, idx is the word k.
    typedef struct packed {
        logic     hit;
        reg_sel_e sel;
        logic [2:0] idx;
    } reg_dec_t;

    // Flat pin number: port-major, 34 functional pins per port.
    function automatic int gpio_flat_idx(input int port, input int bit_idx);
        return port * PinsPerPort + bit_idx;
    endfunction

    // Map a byte address onto the register window; anything else misses.
    function automatic reg_dec_t gpio_decode(input logic [31:0] byte_adr);
        reg_dec_t d;
        d.hit = 1'b0;
        d.sel = REG_IN;
        d.idx = 3'd0;
        for (int k = 0; k < NumInWords; k++) begin
            if (byte_adr == GPIO_IN_BASE + 32'(4 * k)) begin
                d.hit = 1'b1;
                d.sel = REG_IN;
                d.idx = 3'(k);
            end
            if (byte_adr == GPIO_RISE_BASE + 32'(4 * k)) begin
                d.hit = 1'b1;
                d.sel = REG_RISE;
                d.idx = 3'(k);
            end
            if (byte_adr == GPIO_FALL_BASE + 32'(4 * k)) begin
                d.hit = 1'b1;
                d.sel = REG_FALL;
                d.idx = 3'(k);
            end
        end
        if (byte_adr == GPIO_FILT_ADR) begin
            d.hit = 1'b1;
            d.sel = REG_FILT;
            d.idx = 3'd0;
        end
        return d;
    endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// One input pin: 2-flop synchroniser, glitch filter with programmable
// threshold, and single-cycle rise/fall pulses aligned with the filtered level.
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int FiltWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pad_i,
    input  logic [FiltWidth-1:0] thresh_i,
    output logic                 filt_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    logic                 s1_q;
    logic                 s2_q;
    logic                 f_q;
    logic                 f_d;
    logic [FiltWidth-1:0] c_q;
    logic [FiltWidth-1:0] c_d;

    // Filter: accept a new level only after it disagrees with f for thresh_i cycles.
    // Comparing with >= lets a lowered threshold take effect on the next mismatch.
    always_comb begin
        f_d = f_q;
        c_d = c_q;
        if (thresh_i == '0) begin
            f_d = s2_q;
            c_d = '0;
        end else if (s2_q == f_q) begin
            c_d = '0;
        end else if (c_q >= thresh_i - FiltWidth'(1)) begin
            f_d = s2_q;
            c_d = '0;
        end else begin
            c_d = c_q + FiltWidth'(1);
        end
    end

    // Synchroniser, filtered level and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            f_q  <= 1'b0;
            c_q  <= '0;
        end else begin
            s1_q <= pad_i;
            s2_q <= s1_q;
            f_q  <= f_d;
            c_q  <= c_d;
        end
    end

    assign filt_o = f_q;
    // Pulses are derived from the next filtered value so the sticky flags
    // update on the same edge that f changes.
    assign rise_o = f_d & ~f_q;
    assign fall_o = ~f_d & f_q;

endmodule

// File: rtl/gpio_input_capture.sv
// GPIO input capture: per-pin filters, sticky edge flags with W1C clear,
// a threshold register, and a two-stage read pipeline on the register bus.
//
// Bus strobes: write_reg and read_reg are single-cycle strobes qualified by
// chip_sel and sampled at the clock edge ending the cycle. A write takes effect
// at that edge. A read sampled at that edge returns busdata_out with
// read_valid high for exactly one cycle, two cycles after the strobe; there is
// no backpressure. If both strobes are high the write happens and the read is
// dropped. Unmapped addresses ignore writes and produce no read_valid.
module gpio_input_capture
    import gpio_pkg::*;
#(
    parameter int AddrWidth      = 16,
    parameter int BusWidth       = 32,
    parameter int GPIOWidth      = 36,
    parameter int MuxGPIOIOWidth = 34,
    parameter int NumGPIO        = 1,
    parameter int FiltWidth      = 4
) (
    input  logic                                        reg_clk,
    input  logic                                        reset_in,
    input  logic                                        chip_sel,
    input  logic                                        write_reg,
    input  logic                                        read_reg,
    input  logic [AddrWidth-1:2]                        busaddress,
    input  logic [BusWidth-1:0]                         busdata_in,
    input  logic [NumGPIO-1:0][GPIOWidth-1:0]           io_read_data,
    output logic [BusWidth-1:0]                         busdata_out,
    output logic                                        read_valid,
    output logic [NumGPIO-1:0][MuxGPIOIOWidth-1:0]      in_filtered,
    output logic                                        edge_irq
);

    localparam int NumPins = NumGPIO * MuxGPIOIOWidth;
    localparam int PadBits = NumInWords * PinsPrWord;

    logic [NumPins-1:0]   filt;
    logic [NumPins-1:0]   rise_set;
    logic [NumPins-1:0]   fall_set;
    logic [NumPins-1:0]   rise_clr;
    logic [NumPins-1:0]   fall_clr;
    logic [NumPins-1:0]   rise_q;
    logic [NumPins-1:0]   fall_q;
    logic [FiltWidth-1:0] thresh_q;
    logic                 edge_irq_q;

    logic [31:0]          byte_adr;
    reg_dec_t             bus_dec;
    logic                 wr_en;
    logic                 rd_en;

    reg_dec_t             rd_q;
    logic [BusWidth-1:0]  rd_word;
    logic [BusWidth-1:0]  busdata_out_q;
    logic                 read_valid_q;

    logic [PadBits-1:0]   filt_pad;
    logic [PadBits-1:0]   rise_pad;
    logic [PadBits-1:0]   fall_pad;

    // LED pins and the unused upper write-data bits are deliberately ignored.
    logic [NumGPIO-1:0]   unused_led;
    logic                 unused_bus;
    assign unused_bus = ^busdata_in[BusWidth-1:PinsPrWord];

    // One filter per functional pin; the two LED pins per port are skipped.
    for (genvar p = 0; p < NumGPIO; p++) begin : g_port
        assign unused_led[p] = ^io_read_data[p][GPIOWidth-1:MuxGPIOIOWidth];
        for (genvar b = 0; b < MuxGPIOIOWidth; b++) begin : g_pin
            localparam int N = gpio_flat_idx(p, b);
            gpio_pin_filter #(
                .FiltWidth (FiltWidth)
            ) u_pin (
                .clk_i    (reg_clk),
                .rst_i    (reset_in),
                .pad_i    (io_read_data[p][b]),
                .thresh_i (thresh_q),
                .filt_o   (filt[N]),
                .rise_o   (rise_set[N]),
                .fall_o   (fall_set[N])
            );
            assign in_filtered[p][b] = filt[N];
        end
    end

    assign byte_adr = 32'({busaddress, 2'b00});
    assign bus_dec  = gpio_decode(byte_adr);
    assign wr_en    = chip_sel & write_reg & bus_dec.hit;
    assign rd_en    = chip_sel & read_reg & ~write_reg & bus_dec.hit;

    // W1C masks: a write to word k clears the flags of pins 24k..24k+23.
    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        for (int n = 0; n < NumPins; n++) begin
            if (wr_en && (bus_dec.idx == 3'(n / PinsPrWord))) begin
                if (bus_dec.sel == REG_RISE) rise_clr[n] = busdata_in[n % PinsPrWord];
                if (bus_dec.sel == REG_FALL) fall_clr[n] = busdata_in[n % PinsPrWord];
            end
        end
    end

    // Sticky edge flags; a new edge in the same cycle as a clear keeps the flag set.
    always_ff @(posedge reg_clk) begin
        if (reset_in) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= (rise_q & ~rise_clr) | rise_set;
            fall_q <= (fall_q & ~fall_clr) | fall_set;
        end
    end

    // Filter threshold register.
    always_ff @(posedge reg_clk) begin
        if (reset_in) begin
            thresh_q <= '0;
        end else if (wr_en && (bus_dec.sel == REG_FILT)) begin
            thresh_q <= busdata_in[FiltWidth-1:0];
        end
    end

    // Interrupt level follows the flags one cycle later.
    always_ff @(posedge reg_clk) begin
        if (reset_in) begin
            edge_irq_q <= 1'b0;
        end else begin
            edge_irq_q <= (|rise_q) | (|fall_q);
        end
    end

    // Read stage 1: capture the decoded read request.
    always_ff @(posedge reg_clk) begin
        if (reset_in) begin
            rd_q <= '0;
        end else begin
            rd_q <= '{hit: rd_en, sel: bus_dec.sel, idx: bus_dec.idx};
        end
    end

    // Pins beyond NumGPIO*34 read as zero through the padding.
    assign filt_pad = PadBits'(filt);
    assign rise_pad = PadBits'(rise_q);
    assign fall_pad = PadBits'(fall_q);

    // Select the requested word from the state as it stands after stage 1.
    always_comb begin
        rd_word = '0;
        case (rd_q.sel)
            REG_IN:   rd_word[PinsPrWord-1:0] = filt_pad[rd_q.idx * PinsPrWord +: PinsPrWord];
            REG_RISE: rd_word[PinsPrWord-1:0] = rise_pad[rd_q.idx * PinsPrWord +: PinsPrWord];
            REG_FALL: rd_word[PinsPrWord-1:0] = fall_pad[rd_q.idx * PinsPrWord +: PinsPrWord];
            REG_FILT: rd_word[FiltWidth-1:0]  = thresh_q;
            default:  rd_word = '0;
        endcase
    end

    // Read stage 2: registered data, forced to zero when not valid.
    always_ff @(posedge reg_clk) begin
        if (reset_in) begin
            busdata_out_q <= '0;
            read_valid_q  <= 1'b0;
        end else begin
            busdata_out_q <= rd_q.hit ? rd_word : '0;
            read_valid_q  <= rd_q.hit;
        end
    end

    assign busdata_out = busdata_out_q;
    assign read_valid  = read_valid_q;
    assign edge_irq    = edge_irq_q;

endmodule

// File: tb/tb_gpio_input_capture.sv
// Self-checking bench for gpio_input_capture with two ports (68 pins).
module tb_gpio_input_capture;

    localparam int NG = 2;
    localparam int NP = NG * 34;

    logic                   reg_clk = 1'b0;
    logic                   reset_in;
    logic                   chip_sel;
    logic                   write_reg;
    logic                   read_reg;
    logic [15:2]            busaddress;
    logic [31:0]            busdata_in;
    logic [NG-1:0][35:0]    io_read_data;
    logic [31:0]            busdata_out;
    logic                   read_valid;
    logic [NG-1:0][33:0]    in_filtered;
    logic                   edge_irq;

    gpio_input_capture #(
        .AddrWidth      (16),
        .BusWidth       (32),
        .GPIOWidth      (36),
        .MuxGPIOIOWidth (34),
        .NumGPIO        (NG),
        .FiltWidth      (4)
    ) dut (
        .reg_clk      (reg_clk),
        .reset_in     (reset_in),
        .chip_sel     (chip_sel),
        .write_reg    (write_reg),
        .read_reg     (read_reg),
        .busaddress   (busaddress),
        .busdata_in   (busdata_in),
        .io_read_data (io_read_data),
        .busdata_out  (busdata_out),
        .read_valid   (read_valid),
        .in_filtered  (in_filtered),
        .edge_irq     (edge_irq)
    );

    // ---------------- clock / reset ----------------
    always #5 reg_clk = ~reg_clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each pin's level reaches the filter two cycles after the pad; the
    // filtered level adopts it once it has disagreed for thr_m consecutive
    // cycles (immediately when thr_m is 0).
    bit  s1_m[NP];
    bit  s2_m[NP];
    bit  f_m[NP];
    bit  rise_m[NP];
    bit  fall_m[NP];
    int  run_m[NP];
    int  thr_m;
    bit  irq_m;
    bit  rv1_m;
    bit  rv2_m;
    logic [31:0] exp_q[$];

    logic [15:0] m_adr;
    int  m_grp;
    int  m_k;
    bit  m_hit;
    bit  m_wr;
    bit  m_rd;
    bit  m_any;
    bit  m_oldf;
    bit  m_clr;

    function automatic bit addr_map(input logic [15:0] a, output int grp, output int k);
        int off;
        off = int'(a) - 'h1400;
        grp = 0;
        k = 0;
        if (off < 0 || off >= 128) return 1'b0;
        grp = off / 32;
        k = (off % 32) / 4;
        return (grp < 3 && k < 6) || (grp == 3 && k == 0);
    endfunction

    function automatic logic [31:0] model_word(input int grp, input int k);
        logic [31:0] w;
        w = '0;
        if (grp == 3) begin
            w = 32'(thr_m);
        end else begin
            for (int j = 0; j < 24; j++) begin
                int n;
                n = 24 * k + j;
                if (n < NP) begin
                    if (grp == 0) w[j] = f_m[n];
                    if (grp == 1) w[j] = rise_m[n];
                    if (grp == 2) w[j] = fall_m[n];
                end
            end
        end
        return w;
    endfunction

    initial forever begin
        @(posedge reg_clk);
        if (reset_in) begin
            for (int n = 0; n < NP; n++) begin
                s1_m[n] = 0; s2_m[n] = 0; f_m[n] = 0;
                rise_m[n] = 0; fall_m[n] = 0; run_m[n] = 0;
            end
            thr_m = 0;
            irq_m = 0;
            rv1_m = 0;
            rv2_m = 0;
            exp_q.delete();
        end else begin
            m_adr = {busaddress, 2'b00};
            m_hit = addr_map(m_adr, m_grp, m_k);
            m_wr  = chip_sel && write_reg && m_hit;
            m_rd  = chip_sel && read_reg && !write_reg && m_hit;
            m_any = 0;
            for (int n = 0; n < NP; n++) m_any = m_any | rise_m[n] | fall_m[n];
            for (int n = 0; n < NP; n++) begin
                m_oldf = f_m[n];
                if (s2_m[n] != f_m[n]) begin
                    run_m[n] = run_m[n] + 1;
                    if (run_m[n] >= thr_m) begin
                        f_m[n] = s2_m[n];
                        run_m[n] = 0;
                    end
                end else begin
                    run_m[n] = 0;
                end
                m_clr = m_wr && (n / 24 == m_k) && busdata_in[n % 24];
                rise_m[n] = (rise_m[n] && !(m_clr && m_grp == 1)) || (!m_oldf && f_m[n]);
                fall_m[n] = (fall_m[n] && !(m_clr && m_grp == 2)) || (m_oldf && !f_m[n]);
                s2_m[n] = s1_m[n];
                s1_m[n] = io_read_data[n / 34][n % 34];
            end
            if (m_wr && m_grp == 3) thr_m = int'(busdata_in[3:0]);
            irq_m = m_any;
            rv2_m = rv1_m;
            rv1_m = m_rd;
            if (m_rd) exp_q.push_back(model_word(m_grp, m_k));
        end
    end

    // ---------------- scoreboard: compare every cycle ----------------
    logic [NG-1:0][33:0] exp_filt;
    logic [31:0]         exp_rd;

    initial forever begin
        @(negedge reg_clk);
        if (check_en) begin
            exp_filt = '0;
            for (int n = 0; n < NP; n++) exp_filt[n / 34][n % 34] = f_m[n];
            check("in_filtered", in_filtered, exp_filt);
            check("edge_irq", edge_irq, irq_m);
            check("read_valid", read_valid, rv2_m);
            if (rv2_m) begin
                if (exp_q.size() == 0) begin
                    exp_rd = 32'hDEAD_BEEF;
                end else begin
                    exp_rd = exp_q.pop_front();
                end
                check("busdata_out", busdata_out, exp_rd);
            end else begin
                check("busdata_out_idle", busdata_out, 32'h0);
            end
        end
    end

    // ---------------- driver tasks (called right after a negedge) ----------------
    task automatic set_pin(input int n, input logic v);
        io_read_data[n / 34][n % 34] = v;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge reg_clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        chip_sel   = 1'b1;
        write_reg  = 1'b1;
        busaddress = a[15:2];
        busdata_in = d;
        @(negedge reg_clk);
        chip_sel   = 1'b0;
        write_reg  = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [15:0] a, input logic [31:0] lit);
        chip_sel   = 1'b1;
        read_reg   = 1'b1;
        busaddress = a[15:2];
        @(negedge reg_clk);
        chip_sel   = 1'b0;
        read_reg   = 1'b0;
        @(negedge reg_clk);
        check({name, "_valid"}, read_valid, 1'b1);
        check(name, busdata_out, lit);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [15:0] rnd_a;
    int          op;

    initial begin
        reset_in     = 1'b1;
        chip_sel     = 1'b0;
        write_reg    = 1'b0;
        read_reg     = 1'b0;
        busaddress   = '0;
        busdata_in   = '0;
        io_read_data = '0;
        @(negedge reg_clk);
        check_en = 1'b1;
        idle(2);
        reset_in = 1'b0;
        idle(1);

        // reset state
        check("rst_busdata_out", busdata_out, 32'h0);
        check("rst_read_valid", read_valid, 1'b0);
        check("rst_in_filtered", in_filtered, '0);
        check("rst_edge_irq", edge_irq, 1'b0);
        read_expect("rst_rd_1400", 16'h1400, 32'h0);
        read_expect("rst_rd_1460", 16'h1460, 32'h0);

        // T=0: pin 5 reaches f on the third edge
        set_pin(5, 1'b1);
        idle(2);
        check("t0_pin5_early", in_filtered[0][5], 1'b0);
        idle(1);
        check("t0_pin5_lat", in_filtered[0][5], 1'b1);
        idle(1);
        check("t0_irq_set", edge_irq, 1'b1);
        read_expect("t0_rise_1420", 16'h1420, 32'h0000_0020);
        bus_write(16'h1420, 32'h0000_0020);
        read_expect("t0_rise_cleared", 16'h1420, 32'h0);
        check("t0_irq_clear", edge_irq, 1'b0);
        read_expect("t0_fall_1440", 16'h1440, 32'h0);

        // T=4: short pulse rejected, full-length pulse accepted
        bus_write(16'h1460, 32'h0000_0004);
        read_expect("t4_thresh", 16'h1460, 32'h0000_0004);
        set_pin(30, 1'b1);
        idle(3);
        set_pin(30, 1'b0);
        idle(10);
        check("t4_short_pulse", in_filtered[0][30], 1'b0);
        read_expect("t4_short_rise", 16'h1424, 32'h0);
        set_pin(30, 1'b1);
        idle(4);
        set_pin(30, 1'b0);
        idle(12);
        read_expect("t4_pulse_rise", 16'h1424, 32'h0000_0040);
        read_expect("t4_pulse_fall", 16'h1444, 32'h0000_0040);
        set_pin(29, 1'b1);
        idle(5);
        check("t4_step_early", in_filtered[0][29], 1'b0);
        idle(1);
        check("t4_step_lat", in_filtered[0][29], 1'b1);

        // second port: pin 34 is word 1 bit 10
        set_pin(34, 1'b1);
        idle(8);
        check("p1_level", in_filtered[1][0], 1'b1);
        set_pin(34, 1'b0);
        idle(8);
        read_expect("p1_rise_1424", 16'h1424, 32'h0000_0460);
        read_expect("p1_fall_1444", 16'h1444, 32'h0000_0440);
        read_expect("p1_level_1404", 16'h1404, 32'h0000_0020);

        // W1C on the same edge as a new rise: the rise wins
        bus_write(16'h1460, 32'h0);
        set_pin(7, 1'b1);
        idle(2);
        bus_write(16'h1420, 32'h0000_0080);
        read_expect("w1c_collide", 16'h1420, 32'h0000_0080);
        bus_write(16'h1420, 32'h0000_0080);
        read_expect("w1c_after", 16'h1420, 32'h0);

        // back-to-back reads, the last one unmapped
        chip_sel   = 1'b1;
        read_reg   = 1'b1;
        busaddress = 14'(16'h1400 >> 2);
        @(negedge reg_clk);
        busaddress = 14'(16'h1404 >> 2);
        @(negedge reg_clk);
        check("b2b_valid0", read_valid, 1'b1);
        check("b2b_data0", busdata_out, 32'h0000_00A0);
        busaddress = 14'(16'h1500 >> 2);
        @(negedge reg_clk);
        chip_sel = 1'b0;
        read_reg = 1'b0;
        check("b2b_valid1", read_valid, 1'b1);
        check("b2b_data1", busdata_out, 32'h0000_0020);
        @(negedge reg_clk);
        check("b2b_unmapped", read_valid, 1'b0);

        // simultaneous read and write: write lands, read dropped
        chip_sel   = 1'b1;
        write_reg  = 1'b1;
        read_reg   = 1'b1;
        busaddress = 14'(16'h1460 >> 2);
        busdata_in = 32'h0000_0002;
        @(negedge reg_clk);
        chip_sel  = 1'b0;
        write_reg = 1'b0;
        read_reg  = 1'b0;
        @(negedge reg_clk);
        check("rw_no_valid0", read_valid, 1'b0);
        @(negedge reg_clk);
        check("rw_no_valid1", read_valid, 1'b0);
        read_expect("rw_thresh", 16'h1460, 32'h0000_0002);

        // randomized traffic against the model, with a reset in the middle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chip_sel  = 1'b0;
            write_reg = 1'b0;
            read_reg  = 1'b0;
            reset_in  = (cyc == 1500 || cyc == 1501);
            for (int n = 0; n < NP; n++) begin
                if ($urandom_range(0, 7) == 0)
                    io_read_data[n / 34][n % 34] = ~io_read_data[n / 34][n % 34];
            end
            for (int p = 0; p < NG; p++) io_read_data[p][35:34] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0)
                rnd_a = 16'($urandom_range(0, 16383) << 2);
            else
                rnd_a = 16'h1400 + 16'($urandom_range(0, 31) * 4);
            busaddress = rnd_a[15:2];
            busdata_in = $urandom();
            if (rnd_a == 16'h1460) busdata_in = 32'($urandom_range(0, 5));
            op = $urandom_range(0, 15);
            if (op < 5) begin
                chip_sel = ($urandom_range(0, 7) != 0);
                read_reg = 1'b1;
            end else if (op < 7) begin
                chip_sel  = 1'b1;
                write_reg = 1'b1;
            end else if (op == 7) begin
                chip_sel  = 1'b1;
                write_reg = 1'b1;
                read_reg  = 1'b1;
            end
            @(negedge reg_clk);
        end
        chip_sel  = 1'b0;
        write_reg = 1'b0;
        read_reg  = 1'b0;
        reset_in  = 1'b0;
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
